// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - interrupt entry / RTI return sequencer beside the execute stage
// Drains the pipeline, then moves PC and flags through the stack via the memory stage.
module interrupt_sequencer #(
   parameter int DRAIN_CYCLES = 3,
   parameter int PC_WIDTH     = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                int_req,
   input  logic                rti_decoded,
   input  logic [PC_WIDTH-1:0] pc_current,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic [2:0]          flags_in,
   input  logic [15:0]         pop_data,
   output logic                stall_fetch,
   output logic                flush_decode,
   output logic                mem_push,
   output logic                mem_pop,
   output logic [15:0]         push_data,
   output logic                pc_choose_interrupt,
   output logic                pc_choose_memory,
   output logic                flags_restore_en,
   output logic [2:0]          flags_out,
   output logic [PC_WIDTH-1:0] pc_restore,
   output logic                pc_restore_valid,
   output logic                busy
);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_DRAIN      = 4'd1;
   localparam logic [3:0] S_PUSH_PC_HI = 4'd2;
   localparam logic [3:0] S_PUSH_PC_LO = 4'd3;
   localparam logic [3:0] S_PUSH_FLAGS = 4'd4;
   localparam logic [3:0] S_VECTOR     = 4'd5;
   localparam logic [3:0] S_RTI_DRAIN  = 4'd6;
   localparam logic [3:0] S_POP_FLAGS  = 4'd7;
   localparam logic [3:0] S_POP_PC_LO  = 4'd8;
   localparam logic [3:0] S_POP_PC_HI  = 4'd9;
   localparam logic [3:0] S_RTI_LOAD   = 4'd10;

   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

   logic [3:0]          state;
   logic                pending;
   logic [PC_WIDTH-1:0] saved_pc;
   logic [15:0]         pc_lo;
   logic [3:0]          drain_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         pending   <= 1'b0;
         saved_pc  <= '0;
         pc_lo     <= '0;
         drain_cnt <= '0;
      end else begin
         // Requests that cannot be taken right now are remembered once; repeats merge.
         if (int_req && (state != S_IDLE || rti_decoded))
            pending <= 1'b1;

         case (state)
            S_IDLE: begin
               if (rti_decoded) begin
                  state     <= S_RTI_DRAIN;
                  drain_cnt <= DRAIN_INIT;
               end else if (int_req || pending) begin
                  state     <= S_DRAIN;
                  drain_cnt <= DRAIN_INIT;
                  saved_pc  <= pc_current;
                  pending   <= 1'b0;
               end
            end
            S_DRAIN: begin
               // A branch resolving while draining changes where we must return to.
               if (branch_taken)
                  saved_pc <= branch_target;
               if (drain_cnt == 4'd0)
                  state <= S_PUSH_PC_HI;
               else
                  drain_cnt <= drain_cnt - 4'd1;
            end
            S_PUSH_PC_HI: state <= S_PUSH_PC_LO;
            S_PUSH_PC_LO: state <= S_PUSH_FLAGS;
            S_PUSH_FLAGS: state <= S_VECTOR;
            S_VECTOR:     state <= S_IDLE;
            S_RTI_DRAIN: begin
               if (drain_cnt == 4'd0)
                  state <= S_POP_FLAGS;
               else
                  drain_cnt <= drain_cnt - 4'd1;
            end
            S_POP_FLAGS: state <= S_POP_PC_LO;
            S_POP_PC_LO: state <= S_POP_PC_HI;
            S_POP_PC_HI: begin
               pc_lo <= pop_data;
               state <= S_RTI_LOAD;
            end
            S_RTI_LOAD: state <= S_IDLE;
            default:    state <= S_IDLE;
         endcase
      end
   end

   assign busy        = (state != S_IDLE);
   assign stall_fetch = busy;

   // pop_data lags mem_pop by one cycle, so each pop state consumes the previous pop's word.
   always_comb begin
      flush_decode        = 1'b0;
      mem_push            = 1'b0;
      mem_pop             = 1'b0;
      push_data           = 16'h0000;
      pc_choose_interrupt = 1'b0;
      pc_choose_memory    = 1'b0;
      flags_restore_en    = 1'b0;
      flags_out           = 3'b000;
      pc_restore          = '0;
      pc_restore_valid    = 1'b0;
      case (state)
         S_DRAIN, S_RTI_DRAIN: flush_decode = 1'b1;
         S_PUSH_PC_HI: begin
            mem_push  = 1'b1;
            push_data = saved_pc[PC_WIDTH-1:16];
         end
         S_PUSH_PC_LO: begin
            mem_push  = 1'b1;
            push_data = saved_pc[15:0];
         end
         S_PUSH_FLAGS: begin
            mem_push  = 1'b1;
            push_data = {13'b0, flags_in};
         end
         S_VECTOR: begin
            pc_choose_interrupt = 1'b1;
            pc_choose_memory    = 1'b1;
         end
         S_POP_FLAGS: mem_pop = 1'b1;
         S_POP_PC_LO: begin
            mem_pop          = 1'b1;
            flags_restore_en = 1'b1;
            flags_out        = pop_data[2:0];
         end
         S_POP_PC_HI: mem_pop = 1'b1;
         S_RTI_LOAD: begin
            pc_restore       = {pop_data, pc_lo};
            pc_restore_valid = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - self-checking bench for interrupt_sequencer
// Directed scenarios plus a randomised run against a phase-count reference model.
module tb_interrupt_sequencer;
   localparam int D = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        int_req, rti_decoded, branch_taken;
   logic [31:0] pc_current, branch_target;
   logic [2:0]  flags_in;
   logic [15:0] pop_data;
   logic        stall_fetch, flush_decode, mem_push, mem_pop;
   logic [15:0] push_data;
   logic        pc_choose_interrupt, pc_choose_memory, flags_restore_en;
   logic [2:0]  flags_out;
   logic [31:0] pc_restore;
   logic        pc_restore_valid, busy;

   int n_checks = 0;
   int n_pass   = 0;

   interrupt_sequencer #(.DRAIN_CYCLES(D), .PC_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .int_req(int_req), .rti_decoded(rti_decoded),
      .pc_current(pc_current), .branch_taken(branch_taken), .branch_target(branch_target),
      .flags_in(flags_in), .pop_data(pop_data), .stall_fetch(stall_fetch),
      .flush_decode(flush_decode), .mem_push(mem_push), .mem_pop(mem_pop),
      .push_data(push_data), .pc_choose_interrupt(pc_choose_interrupt),
      .pc_choose_memory(pc_choose_memory), .flags_restore_en(flags_restore_en),
      .flags_out(flags_out), .pc_restore(pc_restore), .pc_restore_valid(pc_restore_valid),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [59:0] outs();
      return {stall_fetch, flush_decode, mem_push, mem_pop, push_data, pc_choose_interrupt,
              pc_choose_memory, flags_restore_en, flags_out, pc_restore, pc_restore_valid, busy};
   endfunction

   function automatic logic [59:0] pack(input logic st, input logic fl, input logic pu,
                                        input logic po, input logic [15:0] pd, input logic ci,
                                        input logic cm, input logic fre, input logic [2:0] fo,
                                        input logic [31:0] pr, input logic prv, input logic bz);
      return {st, fl, pu, po, pd, ci, cm, fre, fo, pr, prv, bz};
   endfunction

   task automatic clear_inputs();
      int_req = 1'b0; rti_decoded = 1'b0; branch_taken = 1'b0;
      pc_current = 32'h0; branch_target = 32'h0; flags_in = 3'b000; pop_data = 16'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      int_req = 1'b1; rti_decoded = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if (outs() !== 60'h0) $display("FAIL reset_hold got=%h exp=%h", outs(), 60'h0);
      else n_pass++;
      @(negedge clk);
      clear_inputs();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         n_checks++;
         if (outs() !== 60'h0) $display("FAIL reset_idle c=%0d got=%h exp=%h", c, outs(), 60'h0);
         else n_pass++;
      end
   endtask

   task automatic test_entry();
      logic [59:0] exp;
      logic [15:0] pd;
      @(negedge clk);
      pc_current = 32'h0001_2345; flags_in = 3'b101; int_req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk); int_req = 1'b0; #1;
         pd = (c == 4) ? 16'h0001 : (c == 5) ? 16'h2345 : (c == 6) ? 16'h0005 : 16'h0000;
         exp = pack(c <= 7, c <= 3, c >= 4 && c <= 6, 1'b0, pd, c == 7, c == 7,
                    1'b0, 3'b000, 32'h0, 1'b0, c <= 7);
         n_checks++;
         if (outs() !== exp) $display("FAIL entry c=%0d got=%h exp=%h", c, outs(), exp);
         else n_pass++;
      end
      clear_inputs();
   endtask

   task automatic test_branch_in_drain();
      logic [59:0] exp;
      logic [15:0] pd;
      @(negedge clk);
      pc_current = 32'h1234_5678; flags_in = 3'b010; int_req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         int_req = 1'b0;
         branch_taken  = (c == 1 || c == 2 || c == 4);
         branch_target = (c == 1) ? 32'h1111_2222 : (c == 2) ? 32'h0000_0040 : 32'hFFFF_FFFF;
         #1;
         pd = (c == 4) ? 16'h0000 : (c == 5) ? 16'h0040 : (c == 6) ? 16'h0002 : 16'h0000;
         exp = pack(c <= 7, c <= 3, c >= 4 && c <= 6, 1'b0, pd, c == 7, c == 7,
                    1'b0, 3'b000, 32'h0, 1'b0, c <= 7);
         n_checks++;
         if (outs() !== exp) $display("FAIL branch c=%0d got=%h exp=%h", c, outs(), exp);
         else n_pass++;
      end
      clear_inputs();
   endtask

   task automatic test_rti();
      logic [59:0] exp;
      @(negedge clk);
      rti_decoded = 1'b1; pop_data = 16'hAAAA;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         rti_decoded = 1'b0;
         pop_data = (c == 5) ? 16'h0003 : (c == 6) ? 16'hBEEF : (c == 7) ? 16'h0001 : 16'hAAAA;
         #1;
         exp = pack(c <= 7, c <= 3, 1'b0, c >= 4 && c <= 6, 16'h0, 1'b0, 1'b0,
                    c == 5, (c == 5) ? 3'b011 : 3'b000, (c == 7) ? 32'h0001_BEEF : 32'h0,
                    c == 7, c <= 7);
         n_checks++;
         if (outs() !== exp) $display("FAIL rti c=%0d got=%h exp=%h", c, outs(), exp);
         else n_pass++;
      end
      clear_inputs();
   endtask

   task automatic test_rti_priority();
      int first_valid, first_push, n_push, n_vec, n_busy;
      logic [15:0] pushed[$];
      first_valid = -1; first_push = -1; n_push = 0; n_vec = 0; n_busy = 0;
      @(negedge clk);
      pc_current = 32'h00AB_CDEF; int_req = 1'b1; rti_decoded = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         rti_decoded = 1'b0;
         int_req = (c == 2 || c == 5);
         #1;
         if (busy) n_busy++;
         if (pc_restore_valid && first_valid < 0) first_valid = c;
         if (mem_push) begin
            if (first_push < 0) first_push = c;
            n_push++;
            pushed.push_back(push_data);
         end
         if (pc_choose_interrupt) n_vec++;
      end
      n_checks++;
      if (first_valid !== 7) $display("FAIL prio_rti_load got=%0d exp=%0d", first_valid, 7);
      else n_pass++;
      n_checks++;
      if (n_push !== 3 || n_vec !== 1)
         $display("FAIL prio_merge pushes=%0d vectors=%0d exp=3/1", n_push, n_vec);
      else n_pass++;
      n_checks++;
      if (!(first_push > first_valid)) $display("FAIL prio_order push=%0d load=%0d", first_push, first_valid);
      else n_pass++;
      n_checks++;
      if (n_busy !== 2 * (D + 4)) $display("FAIL prio_busy got=%0d exp=%0d", n_busy, 2 * (D + 4));
      else n_pass++;
      n_checks++;
      if (pushed.size() < 2 || pushed[0] !== 16'h00AB || pushed[1] !== 16'hCDEF)
         $display("FAIL prio_pc got=%h_%h exp=00ab_cdef",
                  pushed.size() > 0 ? pushed[0] : 16'hx, pushed.size() > 1 ? pushed[1] : 16'hx);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      pc_current = 32'h5555_6666; int_req = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         int_req = (c == 2);
         #1;
      end
      n_checks++;
      if (!(mem_push === 1'b1 && push_data === 16'h6666))
         $display("FAIL mid_push_lo got=%b/%h exp=1/6666", mem_push, push_data);
      else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (outs() !== 60'h0) $display("FAIL mid_async got=%h exp=%h", outs(), 60'h0);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk); #1;
         n_checks++;
         if (outs() !== 60'h0) $display("FAIL mid_after c=%0d got=%h exp=%h", c, outs(), 60'h0);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int m_kind, m_k, run;
      logic m_pending, prev_pop;
      logic [31:0] m_saved;
      logic [15:0] m_lo, e_pd;
      logic e_push, e_pop, e_fre, e_prv, e_vec;
      logic [59:0] exp;
      logic [15:0] stack[$];
      m_kind = 0; m_k = 0; run = 0; m_pending = 1'b0; prev_pop = 1'b0;
      m_saved = 32'h0; m_lo = 16'h0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         int_req       = ($urandom_range(0, 7) == 0);
         rti_decoded   = ($urandom_range(0, 15) == 0);
         branch_taken  = ($urandom_range(0, 3) == 0);
         branch_target = $urandom;
         pc_current    = $urandom;
         flags_in      = 3'($urandom);
         if (prev_pop && stack.size() > 0) pop_data = stack.pop_front();
         else pop_data = 16'($urandom);
         #1;
         e_push = (m_kind == 1 && m_k >= D && m_k <= D + 2);
         e_pop  = (m_kind == 2 && m_k >= D && m_k <= D + 2);
         e_fre  = (m_kind == 2 && m_k == D + 1);
         e_prv  = (m_kind == 2 && m_k == D + 3);
         e_vec  = (m_kind == 1 && m_k == D + 3);
         e_pd   = 16'h0;
         if (e_push && m_k == D)     e_pd = m_saved[31:16];
         if (e_push && m_k == D + 1) e_pd = m_saved[15:0];
         if (e_push && m_k == D + 2) e_pd = {13'b0, flags_in};
         exp = pack(m_kind != 0, m_kind != 0 && m_k < D, e_push, e_pop, e_pd, e_vec, e_vec,
                    e_fre, e_fre ? pop_data[2:0] : 3'b000,
                    e_prv ? {pop_data, m_lo} : 32'h0, e_prv, m_kind != 0);
         n_checks++;
         if (outs() !== exp) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, outs(), exp);
         else n_pass++;
         n_checks++;
         if ((mem_push && mem_pop) || stall_fetch !== busy)
            $display("FAIL random_invariant cyc=%0d push=%b pop=%b stall=%b busy=%b",
                     cyc, mem_push, mem_pop, stall_fetch, busy);
         else n_pass++;
         if (mem_push) run++;
         else if (run > 0) begin
            n_checks++;
            if (run !== 3) $display("FAIL random_group cyc=%0d got=%0d exp=3", cyc, run);
            else n_pass++;
            run = 0;
         end
         if (e_push) stack.push_front(e_pd);
         prev_pop = e_pop;
         if (m_kind == 0) begin
            if (rti_decoded) begin
               m_kind = 2; m_k = 0;
               if (int_req) m_pending = 1'b1;
            end else if (int_req || m_pending) begin
               m_kind = 1; m_k = 0; m_saved = pc_current; m_pending = 1'b0;
            end
         end else begin
            if (int_req) m_pending = 1'b1;
            if (m_kind == 1 && m_k < D && branch_taken) m_saved = branch_target;
            if (m_kind == 2 && m_k == D + 2) m_lo = pop_data;
            m_k++;
            if (m_k == D + 4) m_kind = 0;
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_entry();
      test_branch_in_drain();
      test_rti();
      test_rti_priority();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
